// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle for param_sync_fifo. The FIFO sits on the slave
// modport; the producer/consumer logic driving it uses the master modport.
interface param_sync_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              ena;
  logic              flush;
  logic              clr_err;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output ena, flush, clr_err, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  ena, flush, clr_err, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered read port, occupancy count, threshold
// flags and sticky overflow/underflow. DEPTH must be a power of two (2..256).
module param_sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  param_sync_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              live, wr_acc, rd_acc, wr_rej, rd_rej, err_clr;

  always_comb begin
    live    = bus.ena & ~bus.flush;
    rd_acc  = live & bus.rd_en & (count_q != '0);
    // A full FIFO still takes a write when a read frees a slot on the same edge.
    wr_acc  = live & bus.wr_en & ((count_q != FULL_CNT) | rd_acc);
    wr_rej  = live & bus.wr_en & ~wr_acc;
    rd_rej  = live & bus.rd_en & ~rd_acc;
    err_clr = live & bus.clr_err;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;

    if (bus.ena && bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // A new error on the clearing cycle wins, so nothing is silently lost.
    overflow_d  = (overflow_q  & ~err_clr) | wr_rej;
    underflow_d = (underflow_q & ~err_clr) | rd_rej;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = (count_q == FULL_CNT);
  assign bus.empty        = (count_q == '0);
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
